// File: rtl/udp_pkg.sv
// Shared constants, FSM encoding and byte helpers for the UDP receive path.
package udp_pkg;

    localparam int UDP_HEAD_N = 8;   // UDP header length in bytes
    localparam int PORT_W     = 16;  // UDP port / length field width

    // One-hot receive FSM encoding
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_HEAD = 4'b0010,
        ST_DATA = 4'b0100,
        ST_DROP = 4'b1000
    } udp_state_e;

    // Convert a 16-bit field taken little-endian off the bus into its
    // big-endian (network order) value.
    function automatic logic [PORT_W-1:0] bswap16(input logic [PORT_W-1:0] x);
        return {x[7:0], x[15:8]};
    endfunction

endpackage

// File: rtl/udp_port_match.sv
// Destination-port lookup: N_PORT parallel comparators followed by a
// lowest-index-wins priority encoder.
module udp_port_match
    import udp_pkg::*;
#(
    parameter int                        N_PORT    = 4,
    parameter int                        IDX_W     = 2,
    parameter logic [N_PORT*PORT_W-1:0]  DST_PORTS = {N_PORT{16'd18070}}
) (
    input  logic [PORT_W-1:0] i_dst_port,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    logic [N_PORT-1:0] w_eq;

    // Compare the candidate port against every table entry
    always_comb begin
        w_eq = '0;
        for (int i = 0; i < N_PORT; i++) begin
            w_eq[i] = (i_dst_port == DST_PORTS[i*PORT_W +: PORT_W]);
        end
    end

    // Walk from the top entry down so the lowest matching index wins
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = N_PORT - 1; i >= 0; i--) begin
            o_hit = o_hit | w_eq[i];
            o_idx = w_eq[i] ? IDX_W'(i) : o_idx;
        end
    end

endmodule

// File: rtl/udp_rx_mport.sv
// UDP receive filter: strips the 8-byte UDP header from an IP payload
// stream, accepts datagrams addressed to one of several destination ports,
// trims link padding using the UDP length and flags bad datagrams.
module udp_rx_mport
    import udp_pkg::*;
#(
    parameter int                        DATA_W       = 16,
    parameter int                        KEEP_W       = DATA_W / 8,
    parameter int                        LEN_W        = $clog2(KEEP_W + 1),
    parameter int                        N_PORT       = 4,
    parameter logic [N_PORT*PORT_W-1:0]  DST_PORTS    = {N_PORT{16'd18070}},
    parameter int                        SRC_PORT_CHK = 1,
    parameter logic [PORT_W-1:0]         SRC_PORT     = 16'd18070,
    localparam int                       IDX_W        = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cancel_i,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              ip_cs_err_i,
    output logic              valid_o,
    output logic              start_o,
    output logic              last_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic [IDX_W-1:0]  port_idx_o,
    output logic              err_o
);

    localparam int                HEAD_BEATS = 64 / DATA_W;
    localparam int                BEAT_W     = (HEAD_BEATS > 1) ? $clog2(HEAD_BEATS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(HEAD_BEATS - 1);

    udp_state_e        r_state,    w_state_nxt;
    logic [15:0]       r_rem,      w_rem_nxt;
    logic [IDX_W-1:0]  r_port_idx, w_port_idx_nxt;
    logic              r_first,    w_first_nxt;
    logic [BEAT_W-1:0] r_beat,     w_beat_nxt;
    logic [63:0]       r_hdr,      w_hdr_nxt;
    logic              r_ip_err,   w_ip_err_nxt;

    logic [BEAT_W-1:0] w_hidx;
    logic [15:0]       w_src;
    logic [15:0]       w_dst;
    logic [15:0]       w_udp_len;
    logic [15:0]       w_udp_rem;
    logic              w_ip_err_now;
    logic              w_hit;
    logic [IDX_W-1:0]  w_idx;
    logic              w_drop;
    logic              w_decide;
    logic              w_valid;
    logic              w_start;
    logic              w_last;
    logic [LEN_W-1:0]  w_len;
    logic              w_err;

    // Assemble the header: previously captured beats plus the current beat
    // dropped into its slot, so the final header beat is decoded the same cycle.
    always_comb begin
        w_hidx    = (start_i || (HEAD_BEATS == 1)) ? BEAT_W'(0) : r_beat;
        w_hdr_nxt = r_hdr;
        if (valid_i && !cancel_i && (start_i || (r_state == ST_HEAD))) begin
            w_hdr_nxt[int'(w_hidx)*DATA_W +: DATA_W] = data_i;
        end else begin
            w_hdr_nxt = r_hdr;
        end
    end

    assign w_src        = bswap16(w_hdr_nxt[15:0]);
    assign w_dst        = bswap16(w_hdr_nxt[31:16]);
    assign w_udp_len    = bswap16(w_hdr_nxt[47:32]);
    assign w_udp_rem    = w_udp_len - 16'(UDP_HEAD_N);
    assign w_ip_err_now = start_i ? ip_cs_err_i : r_ip_err;

    udp_port_match #(
        .N_PORT    (N_PORT),
        .IDX_W     (IDX_W),
        .DST_PORTS (DST_PORTS)
    ) u_port_match (
        .i_dst_port (w_dst),
        .o_hit      (w_hit),
        .o_idx      (w_idx)
    );

    assign w_drop = w_ip_err_now
                  | ((SRC_PORT_CHK != 0) && (w_src != SRC_PORT))
                  | ~w_hit
                  | (w_udp_len < 16'(UDP_HEAD_N));

    // Decision happens on the last header beat; with a 64-bit bus that is
    // the start beat itself.
    assign w_decide = valid_i & ~cancel_i &
                      (start_i ? (HEAD_BEATS == 1)
                               : ((r_state == ST_HEAD) && (r_beat == BEAT_LAST)));

    // Next-state and zero-latency output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_port_idx_nxt = r_port_idx;
        w_first_nxt    = r_first;
        w_beat_nxt     = r_beat;
        w_ip_err_nxt   = r_ip_err;
        w_valid        = 1'b0;
        w_start        = 1'b0;
        w_last         = 1'b0;
        w_len          = '0;
        w_err          = 1'b0;

        if (cancel_i) begin
            // Cancel beats everything else on the same cycle
            w_state_nxt = ST_IDLE;
            w_first_nxt = 1'b0;
            w_err       = (r_state == ST_HEAD) || (r_state == ST_DATA);
        end else if (valid_i && start_i) begin
            // New datagram always restarts header decode, abandoning any in flight
            w_err        = (r_state == ST_HEAD) || (r_state == ST_DATA);
            w_ip_err_nxt = ip_cs_err_i;
            w_beat_nxt   = BEAT_W'(1);
            w_first_nxt  = 1'b0;
            w_state_nxt  = ST_HEAD;
        end else if (valid_i) begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_IDLE;
                ST_DROP: w_state_nxt = ST_DROP;
                ST_HEAD: w_beat_nxt  = r_beat + BEAT_W'(1);
                ST_DATA: begin
                    w_valid     = 1'b1;
                    w_start     = r_first;
                    w_first_nxt = 1'b0;
                    if (16'(len_i) >= r_rem) begin
                        // Final payload bytes; anything beyond is padding
                        w_last      = 1'b1;
                        w_len       = LEN_W'(r_rem);
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_len = len_i;
                    end
                    w_rem_nxt = r_rem - 16'(w_len);
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end

        if (w_decide) begin
            if (w_drop) begin
                w_state_nxt = ST_DROP;
                w_err       = 1'b1;
            end else begin
                w_port_idx_nxt = w_idx;
                w_rem_nxt      = w_udp_rem;
                w_first_nxt    = 1'b1;
                w_state_nxt    = (w_udp_rem == 16'd0) ? ST_IDLE : ST_DATA;
            end
        end else begin
            w_port_idx_nxt = w_port_idx_nxt;
        end
    end

    // State, remaining-length, port index and header capture registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= ST_IDLE;
            r_rem      <= 16'd0;
            r_port_idx <= '0;
            r_first    <= 1'b0;
            r_beat     <= '0;
            r_hdr      <= 64'd0;
            r_ip_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_port_idx <= w_port_idx_nxt;
            r_first    <= w_first_nxt;
            r_beat     <= w_beat_nxt;
            r_hdr      <= w_hdr_nxt;
            r_ip_err   <= w_ip_err_nxt;
        end
    end

    // Outputs are forced quiet while reset is held, even with inputs active
    assign valid_o    = nreset & w_valid;
    assign start_o    = nreset & w_start;
    assign last_o     = nreset & w_last;
    assign err_o      = nreset & w_err;
    assign len_o      = (nreset & w_valid) ? w_len : '0;
    assign data_o     = data_i;
    assign port_idx_o = r_port_idx;

endmodule

// File: tb/tb_udp_rx_mport.sv
// Directed bench for udp_rx_mport: a 16-bit instance with the default port
// table and a 64-bit instance with a two-entry table.
module tb_udp_rx_mport;

    logic clk = 1'b0;
    logic nreset = 1'b0;

    logic        c16, v16, s16, e16;
    logic [15:0] d16;
    logic [1:0]  l16;
    logic        vo16, so16, lo16, eo16;
    logic [15:0] do16;
    logic [1:0]  ln16;
    logic [1:0]  pi16;

    logic        c64, v64, s64, e64;
    logic [63:0] d64;
    logic [3:0]  l64;
    logic        vo64, so64, lo64, eo64;
    logic [63:0] do64;
    logic [3:0]  ln64;
    logic [0:0]  pi64;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    udp_rx_mport dut16 (
        .clk(clk), .nreset(nreset), .cancel_i(c16), .valid_i(v16), .start_i(s16),
        .data_i(d16), .len_i(l16), .ip_cs_err_i(e16),
        .valid_o(vo16), .start_o(so16), .last_o(lo16), .data_o(do16),
        .len_o(ln16), .port_idx_o(pi16), .err_o(eo16)
    );

    udp_rx_mport #(
        .DATA_W(64), .N_PORT(2), .DST_PORTS({16'd2000, 16'd1000})
    ) dut64 (
        .clk(clk), .nreset(nreset), .cancel_i(c64), .valid_i(v64), .start_i(s64),
        .data_i(d64), .len_i(l64), .ip_cs_err_i(e64),
        .valid_o(vo64), .start_o(so64), .last_o(lo64), .data_o(do64),
        .len_o(ln64), .port_idx_o(pi64), .err_o(eo64)
    );

    function automatic logic [15:0] sw16(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    function automatic logic [63:0] hdr64(input logic [15:0] src, dst, ulen);
        return {16'h0000, sw16(ulen), sw16(dst), sw16(src)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // packed as {valid, start, last, len, err}
    task automatic out16(input string tag, input logic v, s, l, input logic [1:0] n, input logic e);
        chk(tag, 64'({vo16, so16, lo16, ln16, eo16}), 64'({v, s, l, n, e}));
    endtask

    task automatic out64(input string tag, input logic v, s, l, input logic [3:0] n, input logic e);
        chk(tag, 64'({vo64, so64, lo64, ln64, eo64}), 64'({v, s, l, n, e}));
    endtask

    task automatic drv16(input logic s, input logic [15:0] d, input logic [1:0] l,
                         input logic c, input logic e);
        @(negedge clk);
        v16 = 1'b1; s16 = s; d16 = d; l16 = l; c16 = c; e16 = e;
        #1;
    endtask

    task automatic idle16();
        @(negedge clk);
        v16 = 1'b0; s16 = 1'b0; c16 = 1'b0; e16 = 1'b0;
        #1;
    endtask

    task automatic drv64(input logic s, input logic [63:0] d, input logic [3:0] l);
        @(negedge clk);
        v64 = 1'b1; s64 = s; d64 = d; l64 = l;
        #1;
    endtask

    task automatic idle64();
        @(negedge clk);
        v64 = 1'b0; s64 = 1'b0;
        #1;
    endtask

    // Header beats 0..2 (src, dst, length); the decision beat is sent by dec16
    task automatic hdr16(input string tag, input logic [15:0] src, dst, ulen,
                         input logic ipe, input logic serr);
        drv16(1'b1, sw16(src), 2'd2, 1'b0, ipe);
        out16({tag, "_h0"}, 1'b0, 1'b0, 1'b0, 2'd0, serr);
        drv16(1'b0, sw16(dst), 2'd2, 1'b0, 1'b0);
        drv16(1'b0, sw16(ulen), 2'd2, 1'b0, 1'b0);
        out16({tag, "_h2"}, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic dec16(input string tag, input logic exp_err);
        drv16(1'b0, 16'h0000, 2'd2, 1'b0, 1'b0);
        out16({tag, "_dec"}, 1'b0, 1'b0, 1'b0, 2'd0, exp_err);
    endtask

    initial begin
        c16 = 1'b0; v16 = 1'b1; s16 = 1'b1; e16 = 1'b1; d16 = 16'hFFFF; l16 = 2'd2;
        c64 = 1'b0; v64 = 1'b1; s64 = 1'b1; e64 = 1'b0; d64 = 64'hFFFF_FFFF_FFFF_FFFF; l64 = 4'd8;

        // Reset: outputs quiet despite an erroneous start beat on the inputs
        #2;
        out16("rst16", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        out64("rst64", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("rst_pidx16", 64'(pi16), 64'd0);
        v16 = 1'b0; s16 = 1'b0; e16 = 1'b0; v64 = 1'b0; s64 = 1'b0;
        #1 nreset = 1'b1;

        // Length 13 -> 5 payload bytes over three 2-byte beats
        hdr16("t1", 16'd18070, 16'd18070, 16'd13, 1'b0, 1'b0);
        dec16("t1", 1'b0);
        drv16(1'b0, 16'hBBAA, 2'd2, 1'b0, 1'b0);
        out16("t1_p1", 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        chk("t1_data", 64'(do16), 64'h0000_0000_0000_BBAA);
        chk("t1_pidx", 64'(pi16), 64'd0);
        drv16(1'b0, 16'hDDCC, 2'd2, 1'b0, 1'b0);
        out16("t1_p2", 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);
        drv16(1'b0, 16'h00EE, 2'd2, 1'b0, 1'b0);
        out16("t1_p3", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        drv16(1'b0, 16'h1234, 2'd2, 1'b0, 1'b0);
        out16("t1_after", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // Unknown destination port -> drop
        hdr16("t2", 16'd18070, 16'd5555, 16'd13, 1'b0, 1'b0);
        dec16("t2", 1'b1);
        drv16(1'b0, 16'hAAAA, 2'd2, 1'b0, 1'b0);
        out16("t2_p1", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        drv16(1'b0, 16'hBBBB, 2'd2, 1'b0, 1'b0);
        out16("t2_p2", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        // IP checksum error on the start beat, then wrong source port
        hdr16("t3", 16'd18070, 16'd18070, 16'd13, 1'b1, 1'b0);
        dec16("t3", 1'b1);
        hdr16("t4", 16'd1234, 16'd18070, 16'd13, 1'b0, 1'b0);
        dec16("t4", 1'b1);

        // UDP length 8: empty datagram, nothing emitted afterwards
        hdr16("t5", 16'd18070, 16'd18070, 16'd8, 1'b0, 1'b0);
        dec16("t5", 1'b0);
        drv16(1'b0, 16'h5555, 2'd2, 1'b0, 1'b0);
        out16("t5_p1", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        // UDP length 6: shorter than the header
        hdr16("t6", 16'd18070, 16'd18070, 16'd6, 1'b0, 1'b0);
        dec16("t6", 1'b1);

        // Cancel together with start on payload beat 2
        hdr16("t7", 16'd18070, 16'd18070, 16'd13, 1'b0, 1'b0);
        dec16("t7", 1'b0);
        drv16(1'b0, 16'h0201, 2'd2, 1'b0, 1'b0);
        out16("t7_p1", 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        drv16(1'b1, 16'h0403, 2'd2, 1'b1, 1'b0);
        out16("t7_cancel", 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        drv16(1'b0, 16'h0605, 2'd2, 1'b0, 1'b0);
        out16("t7_after", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle16();

        // 64-bit bus: one-beat header, length 20 -> 12 payload bytes
        drv64(1'b1, hdr64(16'd18070, 16'd2000, 16'd20), 4'd8);
        out64("t8_dec", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drv64(1'b0, 64'h0807_0605_0403_0201, 4'd8);
        out64("t8_p1", 1'b1, 1'b1, 1'b0, 4'd8, 1'b0);
        chk("t8_pidx", 64'(pi64), 64'd1);
        drv64(1'b0, 64'h0000_0000_0C0B_0A09, 4'd8);
        out64("t8_p2", 1'b1, 1'b0, 1'b1, 4'd4, 1'b0);
        // Length 12: a single padded beat trimmed to 4 bytes
        drv64(1'b1, hdr64(16'd18070, 16'd2000, 16'd12), 4'd8);
        out64("t9_dec", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drv64(1'b0, 64'hFFFF_FFFF_4433_2211, 4'd8);
        out64("t9_p1", 1'b1, 1'b1, 1'b1, 4'd4, 1'b0);
        chk("t9_pidx", 64'(pi64), 64'd1);
        chk("t9_data", do64, 64'hFFFF_FFFF_4433_2211);
        // Entry 0 of the table
        drv64(1'b1, hdr64(16'd18070, 16'd1000, 16'd10), 4'd8);
        drv64(1'b0, 64'h0000_0000_0000_7766, 4'd2);
        out64("t10_p1", 1'b1, 1'b1, 1'b1, 4'd2, 1'b0);
        chk("t10_pidx", 64'(pi64), 64'd0);
        drv64(1'b0, 64'h0000_0000_0000_7766, 4'd2);
        out64("t10_after", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        idle64();

        // New start while in DATA abandons the datagram
        hdr16("t11", 16'd18070, 16'd18070, 16'd13, 1'b0, 1'b0);
        dec16("t11", 1'b0);
        drv16(1'b0, 16'h1111, 2'd2, 1'b0, 1'b0);
        out16("t11_p1", 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        hdr16("t12", 16'd18070, 16'd18070, 16'd13, 1'b0, 1'b1);
        dec16("t12", 1'b0);
        drv16(1'b0, 16'h2222, 2'd2, 1'b0, 1'b0);
        out16("t12_p1", 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
        drv16(1'b0, 16'h3333, 2'd2, 1'b0, 1'b0);
        out16("t12_p2", 1'b1, 1'b0, 1'b0, 2'd2, 1'b0);

        // Asynchronous reset mid-DATA, off the clock edge
        #1 nreset = 1'b0;
        #1;
        out16("t13_rst", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("t13_pidx64", 64'(pi64), 64'd0);
        #1 nreset = 1'b1;
        drv16(1'b0, 16'h4444, 2'd2, 1'b0, 1'b0);
        out16("t13_after", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        hdr16("t14", 16'd18070, 16'd18070, 16'd9, 1'b0, 1'b0);
        dec16("t14", 1'b0);
        drv16(1'b0, 16'h6655, 2'd2, 1'b0, 1'b0);
        out16("t14_p1", 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
        idle16();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
